// File: rtl/wowi_responder.sv
// wowi_responder: word-wide command responder over a byte-addressed memory.
// Words are split into little-endian byte accesses, one byte per cycle.
module wowi_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_BYTES = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             st_read,
  input  logic                             st_write,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [DATA_WIDTH*WORD_BYTES-1:0] write_data,
  output logic [DATA_WIDTH*WORD_BYTES-1:0] read_data,
  output logic                             flip_ready,
  output logic                             wrt_done,
  output logic                             busy,
  input  logic                             ld_en,
  input  logic [ADDR_WIDTH-1:0]            ld_addr,
  input  logic [DATA_WIDTH-1:0]            ld_data
);

  localparam int W     = DATA_WIDTH * WORD_BYTES;
  localparam int IW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    RD_BYTE,
    RD_HOLD,
    WR_BYTE,
    WR_HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IW-1:0]         idx;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [W-1:0]          wdata_q;
  logic [W-1:0]          stage;
  logic [W-1:0]          stage_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0] wr_byte;
  logic                  last;
  logic                  accept_rd;
  logic                  accept_wr;
  logic                  rd_step;
  logic                  wr_step;

  assign cur_addr = base_q + ADDR_WIDTH'(idx);
  assign mem_rd   = mem[cur_addr];
  assign wr_byte  = wdata_q[idx*DATA_WIDTH +: DATA_WIDTH];
  assign last     = (idx == IW'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept_rd  = 1'b0;
    accept_wr  = 1'b0;
    rd_step    = 1'b0;
    wr_step    = 1'b0;
    flip_ready = 1'b0;
    wrt_done   = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (st_read) begin
          accept_rd = 1'b1;
          state_nxt = RD_BYTE;
        end else if (st_write) begin
          accept_wr = 1'b1;
          state_nxt = WR_BYTE;
        end
      end
      RD_BYTE: begin
        rd_step = 1'b1;
        if (last) state_nxt = RD_HOLD;
      end
      RD_HOLD: begin
        flip_ready = 1'b1;
        if (!st_read) state_nxt = IDLE;
      end
      WR_BYTE: begin
        wr_step = 1'b1;
        if (last) state_nxt = WR_HOLD;
      end
      WR_HOLD: begin
        wrt_done = 1'b1;
        if (!st_write) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stage_nxt = stage;
    stage_nxt[idx*DATA_WIDTH +: DATA_WIDTH] = mem_rd;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx       <= '0;
      read_data <= '0;
    end else if (accept_rd || accept_wr) begin
      idx    <= '0;
      base_q <= base_addr;
      if (accept_wr) wdata_q <= write_data;
    end else if (rd_step || wr_step) begin
      idx <= last ? '0 : idx + 1'b1;
      if (rd_step) begin
        stage <= stage_nxt;
        if (last) read_data <= stage_nxt;
      end
    end
  end

  // Command byte is assigned last so it overrides a same-address backdoor load.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (reset && wr_step) mem[cur_addr] <= wr_byte;
  end

endmodule

// File: tb/tb_wowi_responder.sv
// tb_wowi_responder: directed vector table plus multi-cycle corner sequences
// for the word-wide responder (WORD_BYTES=2, 8-bit bytes, 256-byte memory).
module tb_wowi_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_read;
  logic        st_write;
  logic [7:0]  base_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        flip_ready;
  logic        wrt_done;
  logic        busy;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  wowi_responder #(
    .DATA_WIDTH(8),
    .WORD_BYTES(2),
    .ADDR_WIDTH(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .st_read   (st_read),
    .st_write  (st_write),
    .base_addr (base_addr),
    .write_data(write_data),
    .read_data (read_data),
    .flip_ready(flip_ready),
    .wrt_done  (wrt_done),
    .busy      (busy),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  typedef enum logic [1:0] {K_LOAD, K_WRITE, K_READ} kind_t;

  typedef struct {
    kind_t       kind;
    logic [7:0]  addr;
    logic [15:0] data;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d,
                          input string nm);
    int k;
    @(negedge clk);
    st_write   = 1'b1;
    base_addr  = a;
    write_data = d;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) begin
        base_addr  = a ^ 8'h5A;
        write_data = ~d;
      end
    end while (!wrt_done && k < 20);
    check({nm, " wr_lat"}, k, 3);
    @(negedge clk);
    st_write = 1'b0;
    @(posedge clk);
    #1;
    check({nm, " wr_rel"}, {30'd0, wrt_done, busy}, 0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [15:0] exp,
                         input string nm);
    int k;
    @(negedge clk);
    st_read   = 1'b1;
    base_addr = a;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) base_addr = a ^ 8'h5A;
    end while (!flip_ready && k < 20);
    check({nm, " rd_lat"}, k, 3);
    check({nm, " rd_data"}, read_data, exp);
    @(negedge clk);
    st_read = 1'b0;
    @(posedge clk);
    #1;
    check({nm, " rd_rel"}, {30'd0, flip_ready, busy}, 0);
  endtask

  initial begin
    int k;
    reset      = 1'b0;
    st_read    = 1'b0;
    st_write   = 1'b0;
    base_addr  = '0;
    write_data = '0;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;

    tbl[0] = '{K_WRITE, 8'h10, 16'hBEEF};
    tbl[1] = '{K_READ,  8'h10, 16'hBEEF};
    tbl[2] = '{K_LOAD,  8'hFF, 16'h0034};
    tbl[3] = '{K_LOAD,  8'h00, 16'h0012};
    tbl[4] = '{K_READ,  8'hFF, 16'h1234};
    tbl[5] = '{K_WRITE, 8'h50, 16'h2211};
    tbl[6] = '{K_WRITE, 8'h52, 16'h4433};
    tbl[7] = '{K_READ,  8'h51, 16'h3322};
    tbl[8] = '{K_WRITE, 8'hFF, 16'h5566};
    tbl[9] = '{K_READ,  8'hFF, 16'h5566};

    repeat (3) @(posedge clk);
    #1;
    check("reset outs", {read_data, 13'd0, flip_ready, wrt_done, busy}, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      unique case (tbl[i].kind)
        K_LOAD:  load(tbl[i].addr, tbl[i].data[7:0]);
        K_WRITE: do_write(tbl[i].addr, tbl[i].data, $sformatf("v%0d", i));
        default: do_read(tbl[i].addr, tbl[i].data, $sformatf("v%0d", i));
      endcase
    end

    // Level hold: one read only, even if memory changes underneath.
    @(negedge clk);
    st_read   = 1'b1;
    base_addr = 8'h10;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!flip_ready && k < 20);
    check("hold lat", k, 3);
    load(8'h10, 8'h00);
    repeat (5) @(negedge clk);
    check("hold ready", {31'd0, flip_ready}, 1);
    check("hold data", read_data, 16'hBEEF);
    st_read = 1'b0;
    @(posedge clk);
    #1;
    check("hold rel", {30'd0, flip_ready, busy}, 0);
    load(8'h10, 8'hEF);

    // Simultaneous: read first, write after read drops.
    @(negedge clk);
    st_read    = 1'b1;
    st_write   = 1'b1;
    base_addr  = 8'h10;
    write_data = 16'hA5A5;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!flip_ready && k < 20);
    check("sim rd data", read_data, 16'hBEEF);
    check("sim no wr", {31'd0, wrt_done}, 0);
    @(negedge clk);
    st_read = 1'b0;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!wrt_done && k < 20);
    check("sim wr lat", k, 4);
    check("sim rd kept", read_data, 16'hBEEF);
    @(negedge clk);
    st_write = 1'b0;
    @(posedge clk);
    #1;
    check("sim idle", {31'd0, busy}, 0);
    do_read(8'h10, 16'hA5A5, "sim rb");

    // Reset after the first byte of a write.
    load(8'h20, 8'h00);
    load(8'h21, 8'h77);
    @(negedge clk);
    st_write   = 1'b1;
    base_addr  = 8'h20;
    write_data = 16'hCAFE;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    st_write = 1'b0;
    @(posedge clk);
    #1;
    check("rst outs", {read_data, 13'd0, flip_ready, wrt_done, busy}, 0);
    @(negedge clk);
    reset = 1'b1;
    do_read(8'h20, 16'h77FE, "rst rb");

    // Backdoor load colliding with the command's second byte.
    @(negedge clk);
    st_write   = 1'b1;
    base_addr  = 8'h30;
    write_data = 16'h9988;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = 8'h31;
    ld_data = 8'h00;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
    check("col done", {31'd0, wrt_done}, 1);
    @(negedge clk);
    st_write = 1'b0;
    @(posedge clk);
    #1;
    do_read(8'h30, 16'h9988, "col rb");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/wowi_responder.md
# wowi_responder

Responder end of the word-width command interface used by the flip datapath. It accepts word-level read and write commands, each `WORD_BYTES*DATA_WIDTH` bits wide. Each command becomes a sequence of single-byte accesses to an internal byte-addressed memory. The block sits between the flip controller and byte storage, packing bytes into words on reads and unpacking words into bytes on writes.

## Interface

Parameters:

- `DATA_WIDTH`, default 8: byte width in bits.
- `WORD_BYTES`, default 2: bytes per word, must be at least 1. Word width `W = DATA_WIDTH*WORD_BYTES`.
- `ADDR_WIDTH`, default 8: byte address width. Memory depth is `2**ADDR_WIDTH` bytes.

Ports:

- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `st_read` input 1: read command, level.
- `st_write` input 1: write command, level.
- `base_addr` input `ADDR_WIDTH`: byte address of word byte 0.
- `write_data` input `W`: word to store.
- `read_data` output `W`: last word read.
- `flip_ready` output 1: read complete, level.
- `wrt_done` output 1: write complete, level.
- `busy` output 1: high whenever the state is not IDLE.
- `ld_en` input 1: backdoor byte write enable.
- `ld_addr` input `ADDR_WIDTH`: backdoor byte address.
- `ld_data` input `DATA_WIDTH`: backdoor byte data.

## Operation

- **Byte order:** little-endian. Word byte i is bits `[i*DATA_WIDTH +: DATA_WIDTH]`. It lives at address `(base_addr + i) mod 2**ADDR_WIDTH`; addresses wrap past the top of memory.
- **States:** IDLE, RD_BYTE, RD_HOLD, WR_BYTE, WR_HOLD. A byte index counter runs from 0 to `WORD_BYTES-1`.
- **IDLE:**
  - `st_read`=1: capture `base_addr`, clear the index, go to RD_BYTE.
  - Else `st_write`=1: capture `base_addr` and `write_data`, clear the index, go to WR_BYTE.
  - Both high: the read wins. The write is serviced afterwards if `st_write` is still high when the block returns to IDLE.
- **RD_BYTE:**
  - Each cycle, load the memory byte at (captured base + index) into lane `index` of a staging register, then increment the index.
  - After the last byte, copy staging to `read_data` and go to RD_HOLD.
- **RD_HOLD:** `flip_ready`=1. Leave for IDLE when `st_read`=0.
- **WR_BYTE:**
  - Each cycle, write captured-word lane `index` to memory at (captured base + index), then increment the index.
  - After the last byte, go to WR_HOLD.
- **WR_HOLD:** `wrt_done`=1. Leave for IDLE when `st_write`=0.
- **Input sampling:** `base_addr` and `write_data` are sampled only at command acceptance. Later changes are ignored.
- **`read_data`:** holds its value until the next read completes. It is never altered by writes.
- **Backdoor port:** `ld_en` writes `ld_data` to `ld_addr` in any state. If it hits the same address in the same cycle as a WR_BYTE write, the WR_BYTE write wins.
- **Reset:**
  - State goes to IDLE and the index to 0.
  - `read_data`=0, `flip_ready`=0, `wrt_done`=0, `busy`=0.
  - Memory contents are not reset.
  - Reset during WR_BYTE aborts the command; bytes already written stay written.

## Timing

- **Edge numbering:** E0 is the edge at which IDLE samples a command high. Edge E0+k is k cycles after it.
- **Byte cycles:** RD_BYTE or WR_BYTE occupies edges E0+1 through E0+WORD_BYTES, one byte per cycle.
- **Read latency:** `read_data` and `flip_ready` become valid after edge E0+WORD_BYTES, i.e. 3 cycles from command assertion when WORD_BYTES=2.
- **Write latency:** `wrt_done` rises after edge E0+WORD_BYTES. Memory bytes are visible to a subsequent read.
- **Deassertion:** `flip_ready` and `wrt_done` fall one cycle after their command deasserts.
- **Command repeat rate:** the next command can be accepted no earlier than 2 cycles after the deassertion is sampled (HOLD to IDLE, then IDLE accept). This rate is the minimum interval.
- **Busy:** `busy` is high from E0+1 until the HOLD-to-IDLE edge.
- **Held commands:** a command held high continuously never re-triggers. Re-triggering requires passing through IDLE with the command low, or the other command pending.

## Test plan

- **Write then read:** WORD_BYTES=2; write 0xBEEF to base 0x10, then read base 0x10.
  - `mem[0x10]`=0xEF and `mem[0x11]`=0xBE.
  - `wrt_done` is high 2 edges after E0.
  - The read returns 0xBEEF with `flip_ready` high 2 edges after its E0.
- **Wrap-around:** preload `mem[0xFF]`=0x34 and `mem[0x00]`=0x12 via the backdoor; read base 0xFF.
  - `read_data`=0x1234.
- **Level hold:** hold `st_read` high for 10 cycles.
  - Exactly one read occurs.
  - `flip_ready` stays high until 1 cycle after `st_read` falls.
  - `busy` then goes low.
- **Simultaneous commands:** assert `st_read` and `st_write` together with `write_data`=0xA5A5; drop `st_read` once `flip_ready` is high.
  - The read completes first, returning the old data.
  - The write then executes and `wrt_done` rises.
- **Reset mid-write:** write 0xCAFE to base 0x20, and drive `reset` low at E0+1 after the first byte write.
  - `mem[0x20]`=0xFE and `mem[0x21]` is unchanged.
  - All outputs read 0 and the state is IDLE.
- **Backdoor collision:** `ld_en` to 0x31 in the same cycle as the WR_BYTE write to 0x31.
  - The command data is retained at 0x31.
